// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Word-organised data RAM answering the memory-stage dmem ports.
//             Byte/half/word loads and stores with sign/zero extension,
//             fault detection, and a zero-fill sweep after every reset.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemdatain,
  input  logic [2:0]  dmemop,
  input  logic        dmemwe,
  output logic [31:0] dmemdataout,
  output logic        ready,
  output logic        fault,
  output logic [31:0] fault_addr
);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [AW-1:0]   sweep;
  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic            is_half, is_word, illegal, oob, bad_access;
  logic [3:0]      byte_en;
  logic [31:0]     wdata;
  logic [31:0]     rd_shift;

  // Right-aligned data to load format: byte/half extend per op[2], word passes
  function automatic logic [31:0] fmt(input logic [31:0] d, input logic [2:0] op);
    logic [31:0] r;
    r = d;
    case (op[1:0])
      2'b00:   r = op[2] ? {24'd0, d[7:0]}   : {{24{d[7]}}, d[7:0]};
      2'b01:   r = op[2] ? {16'd0, d[15:0]}  : {{16{d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Address decode, fault detection and lane enables for the current access
  always_comb begin
    idx        = dmemaddr[AW+1:2];
    lane       = dmemaddr[1:0];
    is_half    = (dmemop[1:0] == 2'b01);
    is_word    = (dmemop == 3'b010);
    illegal    = (dmemop == 3'b011) || (dmemop[2] && dmemop[1]);
    oob        = ((dmemaddr >> (AW + 2)) != 32'd0);
    bad_access = illegal || (is_half && dmemaddr[0]) ||
                 (is_word && (dmemaddr[1:0] != 2'b00)) || oob;
    byte_en    = 4'b0001 << lane;
    wdata      = {4{dmemdatain[7:0]}};
    if (is_half) begin
      byte_en = dmemaddr[1] ? 4'b1100 : 4'b0011;
      wdata   = {2{dmemdatain[15:0]}};
    end else if (is_word) begin
      byte_en = 4'b1111;
      wdata   = dmemdatain;
    end
    rd_shift   = mem[idx] >> {lane, 3'b000};
  end

  // Next state: INIT runs until the last word is cleared, RUN is terminal
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (sweep == AW'(DEPTH - 1)) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // State register, sweep counter and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= INIT;
      sweep       <= '0;
      ready       <= 1'b0;
      dmemdataout <= 32'd0;
      fault       <= 1'b0;
      fault_addr  <= 32'd0;
    end else begin
      state <= state_next;
      ready <= (state_next == RUN);
      if (state == INIT) begin
        sweep       <= sweep + AW'(1);
        dmemdataout <= 32'd0;
        fault       <= 1'b0;
      end else begin
        fault <= bad_access;
        if (bad_access) begin
          dmemdataout <= 32'd0;
          fault_addr  <= dmemaddr;
        end else if (dmemwe) begin
          // Written lanes equal the right-aligned store data, so the
          // write-first result is just the store data in load format.
          dmemdataout <= fmt(dmemdatain, dmemop);
        end else begin
          dmemdataout <= fmt(rd_shift, dmemop);
        end
      end
    end
  end

  // RAM writes: zero-fill during INIT, byte-enabled stores during RUN
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[sweep] <= 32'd0;
      end else if (dmemwe && !bad_access) begin
        for (int i = 0; i < 4; i++) begin
          if (byte_en[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder (table + scoreboard).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dmemaddr = 32'd0;
  logic [31:0] dmemdatain = 32'd0;
  logic [2:0]  dmemop = 3'b010;
  logic        dmemwe = 1'b0;
  logic [31:0] dmemdataout;
  logic        ready;
  logic        fault;
  logic [31:0] fault_addr;

  dmem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .dmemaddr    (dmemaddr),
    .dmemdatain  (dmemdatain),
    .dmemop      (dmemop),
    .dmemwe      (dmemwe),
    .dmemdataout (dmemdataout),
    .ready       (ready),
    .fault       (fault),
    .fault_addr  (fault_addr)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp;
    logic        exp_fault;
  } vec_t;

  typedef struct packed {
    logic [31:0] dout;
    logic        flt;
    logic [31:0] faddr;
  } exp_t;

  exp_t        sbq[$];
  vec_t        tbl1[24];
  vec_t        tbl2[6];
  logic [31:0] fa_model = 32'd0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    exp_t e;
    dmemwe     = v.we;
    dmemop     = v.op;
    dmemaddr   = v.addr;
    dmemdatain = v.din;
    if (v.exp_fault) fa_model = v.addr;
    e.dout  = v.exp;
    e.flt   = v.exp_fault;
    e.faddr = fa_model;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    if (sbq.size() == 0) begin
      chk({name, " scoreboard"}, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk({name, " dout"},  dmemdataout,        e.dout);
      chk({name, " fault"}, {31'd0, fault},     {31'd0, e.flt});
      chk({name, " faddr"}, fault_addr,         e.faddr);
      chk({name, " ready"}, {31'd0, ready},     32'd1);
    end
  endtask

  // Count cycles until ready, checking that INIT stays quiet meanwhile
  task automatic count_init(input string name);
    int n;
    int noisy;
    n = 0;
    noisy = 0;
    while (ready !== 1'b1 && n < DEPTH + 20) begin
      @(posedge clock);
      #1;
      n++;
      if (fault !== 1'b0 || dmemdataout !== 32'd0) noisy++;
    end
    chk({name, " init cycles"}, n, DEPTH);
    chk({name, " init quiet"}, noisy, 0);
  endtask

  task automatic check_reset_state(input string name);
    chk({name, " rst dout"},  dmemdataout,    32'd0);
    chk({name, " rst fault"}, {31'd0, fault}, 32'd0);
    chk({name, " rst faddr"}, fault_addr,     32'd0);
    chk({name, " rst ready"}, {31'd0, ready}, 32'd0);
  endtask

  initial begin
    //               we    op      addr       din            exp            flt
    tbl1[0]  = '{1'b0, 3'b010, 32'h00, 32'h0,         32'h00000000, 1'b0};
    tbl1[1]  = '{1'b0, 3'b010, 32'h7C, 32'h0,         32'h00000000, 1'b0};
    tbl1[2]  = '{1'b1, 3'b010, 32'h10, 32'h8899AABB,  32'h8899AABB, 1'b0};
    tbl1[3]  = '{1'b0, 3'b000, 32'h11, 32'h0,         32'hFFFFFFAA, 1'b0};
    tbl1[4]  = '{1'b0, 3'b100, 32'h11, 32'h0,         32'h000000AA, 1'b0};
    tbl1[5]  = '{1'b0, 3'b001, 32'h12, 32'h0,         32'hFFFF8899, 1'b0};
    tbl1[6]  = '{1'b0, 3'b101, 32'h10, 32'h0,         32'h0000AABB, 1'b0};
    tbl1[7]  = '{1'b1, 3'b000, 32'h13, 32'h0000005A,  32'h0000005A, 1'b0};
    tbl1[8]  = '{1'b0, 3'b010, 32'h10, 32'h0,         32'h5A99AABB, 1'b0};
    tbl1[9]  = '{1'b1, 3'b010, 32'h22, 32'hDEADBEEF,  32'h00000000, 1'b1};
    tbl1[10] = '{1'b0, 3'b010, 32'h20, 32'h0,         32'h00000000, 1'b0};
    tbl1[11] = '{1'b0, 3'b011, 32'h00, 32'h0,         32'h00000000, 1'b1};
    tbl1[12] = '{1'b0, 3'b010, 32'h80, 32'h0,         32'h00000000, 1'b1};
    tbl1[13] = '{1'b0, 3'b001, 32'h11, 32'h0,         32'h00000000, 1'b1};
    tbl1[14] = '{1'b1, 3'b010, 32'h40, 32'h12345678,  32'h12345678, 1'b0};
    tbl1[15] = '{1'b0, 3'b010, 32'h40, 32'h0,         32'h12345678, 1'b0};
    tbl1[16] = '{1'b1, 3'b101, 32'h42, 32'hFFFF8001,  32'h00008001, 1'b0};
    tbl1[17] = '{1'b0, 3'b010, 32'h40, 32'h0,         32'h80015678, 1'b0};
    tbl1[18] = '{1'b0, 3'b001, 32'h42, 32'h0,         32'hFFFF8001, 1'b0};
    tbl1[19] = '{1'b1, 3'b100, 32'h41, 32'h00000080,  32'h00000080, 1'b0};
    tbl1[20] = '{1'b0, 3'b000, 32'h41, 32'h0,         32'hFFFFFF80, 1'b0};
    tbl1[21] = '{1'b0, 3'b010, 32'h40, 32'h0,         32'h80018078, 1'b0};
    tbl1[22] = '{1'b1, 3'b110, 32'h44, 32'hCAFEF00D,  32'h00000000, 1'b1};
    tbl1[23] = '{1'b0, 3'b010, 32'h44, 32'h0,         32'h00000000, 1'b0};

    tbl2[0]  = '{1'b0, 3'b010, 32'h10, 32'h0,         32'h00000000, 1'b0};
    tbl2[1]  = '{1'b0, 3'b010, 32'h40, 32'h0,         32'h00000000, 1'b0};
    tbl2[2]  = '{1'b0, 3'b010, 32'h00, 32'h0,         32'h00000000, 1'b0};
    tbl2[3]  = '{1'b0, 3'b010, 32'h7C, 32'h0,         32'h00000000, 1'b0};
    tbl2[4]  = '{1'b1, 3'b001, 32'h7E, 32'h0000C3C3,  32'hFFFFC3C3, 1'b0};
    tbl2[5]  = '{1'b0, 3'b010, 32'h7C, 32'h0,         32'hC3C30000, 1'b0};

    // Power-up reset, then the zero-fill sweep
    @(posedge clock);
    #1;
    check_reset_state("por");
    reset = 1'b0;
    count_init("por");

    for (int i = 0; i < 24; i++) apply(tbl1[i], $sformatf("t1v%0d", i));

    // Mid-RUN reset: drive stores to word 0 throughout the sweep
    reset = 1'b1;
    @(posedge clock);
    #1;
    fa_model = 32'd0;
    check_reset_state("mid");
    reset      = 1'b0;
    dmemwe     = 1'b1;
    dmemop     = 3'b010;
    dmemaddr   = 32'h0;
    dmemdatain = 32'hFFFFFFFF;
    count_init("mid");

    for (int i = 0; i < 6; i++) apply(tbl2[i], $sformatf("t2v%0d", i));

    chk("scoreboard empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
